// File: rtl/cgra_reset_seq_if.sv
// cgra_reset_seq_if
// Control and status bundle between the host register block and the reset sequencer.
//   master : host side. It drives start, the sequence configuration, ch_en,
//            irq_in and the watchdog controls. It observes rst_out, busy, done,
//            wd_timeout and heartbeat.
//   slave  : sequencer side. It uses the same signals with the directions reversed.
// Parameters NUM_CH, CNT_W and TIMEOUT_W must match the sequencer instance.
interface cgra_reset_seq_if #(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT_W = 32
);
    logic                 start;
    logic [CNT_W-1:0]     pre_cycles;
    logic [CNT_W-1:0]     hold_cycles;
    logic [CNT_W-1:0]     stagger_cycles;
    logic [NUM_CH-1:0]    ch_en;
    logic [NUM_CH-1:0]    rst_out;
    logic                 busy;
    logic                 done;
    logic                 irq_in;
    logic [TIMEOUT_W-1:0] wd_limit;
    logic                 wd_clear;
    logic                 wd_timeout;
    logic                 heartbeat;

    modport master (
        output start, pre_cycles, hold_cycles, stagger_cycles, ch_en,
        output irq_in, wd_limit, wd_clear,
        input  rst_out, busy, done, wd_timeout, heartbeat
    );

    modport slave (
        input  start, pre_cycles, hold_cycles, stagger_cycles, ch_en,
        input  irq_in, wd_limit, wd_clear,
        output rst_out, busy, done, wd_timeout, heartbeat
    );
endinterface

// File: rtl/cgra_reset_seq.sv
// cgra_reset_seq
// Reset sequencer for bring-up of array sub-domains. A start request produces
// a low-high-low reset pulse on NUM_CH channels. The channels then release one
// after another, spaced by a programmable stagger. After the sequence ends, a
// watchdog waits for an interrupt. A heartbeat pulse runs freely in parallel.
// Ports:
//   clk      : clock
//   reset_n  : asynchronous active-low reset
//   bus      : cgra_reset_seq_if.slave. It carries start, the pre/hold/stagger
//              counts, ch_en, rst_out, busy, done, irq_in, wd_limit, wd_clear,
//              wd_timeout and heartbeat.
// Build option:
//   RESET_SEQ_AUTOSTART_EN : when defined, the sequencer fires one internal
//              start in the first cycle after reset is released. That start
//              uses PRE_DEF, HOLD_DEF and STAG_DEF, with every channel enabled.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for start, rst_out low
// S_PRE     | rst_out held low for max(pre,1) cycles
// S_ASSERT  | rst_out = latched ch_en for max(hold,1) cycles
// S_RELEASE | channel i drops i*stagger cycles after entry; done follows
module cgra_reset_seq #(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 16,
    parameter int TIMEOUT_W = 32,
    parameter int HB_PERIOD = 1000,
    parameter int PRE_DEF   = 3,
    parameter int HOLD_DEF  = 3,
    parameter int STAG_DEF  = 0
) (
    input  logic            clk,
    input  logic            reset_n,
    cgra_reset_seq_if.slave bus
);
    localparam int REL_W = CNT_W + 4;
    localparam int HB_W  = $clog2(HB_PERIOD);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRE,
        S_ASSERT,
        S_RELEASE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    tmr_q, tmr_d;
    logic [REL_W-1:0]    rel_q, rel_d;
    logic [CNT_W-1:0]    hold_q;
    logic [CNT_W-1:0]    stag_q;
    logic [NUM_CH-1:0]   en_q;
    logic                done_q, done_d;
    logic                latch;
    logic [NUM_CH-1:0]   rst_comb;

    logic                 wd_armed_q;
    logic [TIMEOUT_W-1:0] wd_cnt_q;
    logic                 wd_to_q;
    logic [HB_W-1:0]      hb_q;

    logic                auto_start;
    logic                start_req;
    logic [CNT_W-1:0]    cfg_pre, cfg_hold, cfg_stag;
    logic [NUM_CH-1:0]   cfg_en;
    logic [CNT_W-1:0]    pre_tc, hold_tc;
    logic [REL_W-1:0]    rel_span;

`ifdef RESET_SEQ_AUTOSTART_EN
    logic auto_q;

    // auto_q is high while reset is held and for the first cycle after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            auto_q <= 1'b1;
        end else begin
            auto_q <= 1'b0;
        end
    end

    assign auto_start = auto_q;
`else
    assign auto_start = 1'b0;
`endif

    assign start_req = bus.start | auto_start;
    assign cfg_pre   = auto_start ? CNT_W'(PRE_DEF)  : bus.pre_cycles;
    assign cfg_hold  = auto_start ? CNT_W'(HOLD_DEF) : bus.hold_cycles;
    assign cfg_stag  = auto_start ? CNT_W'(STAG_DEF) : bus.stagger_cycles;
    assign cfg_en    = auto_start ? {NUM_CH{1'b1}}   : bus.ch_en;

    // Down-counter terminal values. A count of 0 behaves as 1.
    assign pre_tc  = (cfg_pre  == '0) ? '0 : cfg_pre  - CNT_W'(1);
    assign hold_tc = (cfg_hold == '0) ? '0 : cfg_hold - CNT_W'(1);

    // The RELEASE phase lasts (NUM_CH-1)*stagger + 1 cycles.
    assign rel_span = REL_W'(NUM_CH - 1) * REL_W'(stag_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            tmr_q   <= '0;
            rel_q   <= '0;
            hold_q  <= '0;
            stag_q  <= '0;
            en_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            rel_q   <= rel_d;
            done_q  <= done_d;
            if (latch) begin
                hold_q <= hold_tc;
                stag_q <= cfg_stag;
                en_q   <= cfg_en;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q;
        rel_d    = rel_q;
        done_d   = 1'b0;
        latch    = 1'b0;
        rst_comb = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    state_d = S_PRE;
                    tmr_d   = pre_tc;
                    latch   = 1'b1;
                end
            end
            S_PRE: begin
                if (tmr_q == '0) begin
                    state_d = S_ASSERT;
                    tmr_d   = hold_q;
                end else begin
                    tmr_d = tmr_q - CNT_W'(1);
                end
            end
            S_ASSERT: begin
                rst_comb = en_q;
                if (tmr_q == '0) begin
                    state_d = S_RELEASE;
                    rel_d   = rel_span;
                end else begin
                    tmr_d = tmr_q - CNT_W'(1);
                end
            end
            S_RELEASE: begin
                // rel_q counts down from rel_span. Channel i has been released
                // once rel_q reaches (NUM_CH-1-i)*stagger.
                for (int i = 0; i < NUM_CH; i++) begin
                    rst_comb[i] = en_q[i] &
                                  (rel_q > (REL_W'(NUM_CH - 1 - i) * REL_W'(stag_q)));
                end
                if (rel_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    rel_d = rel_q - REL_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Watchdog. It arms on the edge that raises done. The limit is loaded into
    // a down-counter, so timeout fires wd_limit cycles after done. An accepted
    // start or wd_clear overrides everything else.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_armed_q <= 1'b0;
            wd_cnt_q   <= '0;
            wd_to_q    <= 1'b0;
        end else if (latch || bus.wd_clear) begin
            wd_armed_q <= 1'b0;
            wd_cnt_q   <= '0;
            wd_to_q    <= 1'b0;
        end else if (done_d && (bus.wd_limit != '0)) begin
            wd_armed_q <= 1'b1;
            wd_cnt_q   <= bus.wd_limit;
        end else if (wd_armed_q) begin
            if (bus.irq_in) begin
                wd_armed_q <= 1'b0;
            end else if (wd_cnt_q == TIMEOUT_W'(1)) begin
                wd_armed_q <= 1'b0;
                wd_cnt_q   <= '0;
                wd_to_q    <= 1'b1;
            end else begin
                wd_cnt_q <= wd_cnt_q - TIMEOUT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hb_q <= '0;
        end else if (hb_q == HB_W'(HB_PERIOD - 1)) begin
            hb_q <= '0;
        end else begin
            hb_q <= hb_q + HB_W'(1);
        end
    end

    // rst_out is decoded from state, so an asynchronous reset clears it at once.
    assign bus.rst_out    = rst_comb;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done       = done_q;
    assign bus.wd_timeout = wd_to_q;
    assign bus.heartbeat  = (hb_q == HB_W'(HB_PERIOD - 1));
endmodule
